// File: rtl/fsic_serdes_pkg.sv
// fsic_serdes_pkg: link FSM state encoding and serdes control register constants
package fsic_serdes_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_RX   = 3'd1,
    WR_TX   = 3'd2,
    RD_CHK  = 3'd3,
    WAIT_RX = 3'd4,
    UP      = 3'd5,
    ERR     = 3'd6,
    WR_OFF  = 3'd7
  } link_state_t;
  localparam int unsigned SERDES_CTRL_OFS = 0;
  localparam int unsigned RXEN_BIT = 0;
  localparam int unsigned TXEN_BIT = 1;
endpackage

// File: rtl/serdes_axil_master.sv
// serdes_axil_master: single-beat AXI-lite master, one write or one read in flight at a time
module serdes_axil_master #(
  parameter int pADDR_WIDTH = 15,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                     axi_clk,
  input  logic                     axi_reset_n,
  input  logic                     req,
  input  logic                     we,
  input  logic [pADDR_WIDTH-1:0]   addr,
  input  logic [pDATA_WIDTH-1:0]   wdata,
  output logic                     busy,
  output logic                     done,
  output logic [pDATA_WIDTH-1:0]   rdata,
  output logic                     m_awvalid,
  output logic [pADDR_WIDTH-1:0]   m_awaddr,
  input  logic                     m_awready,
  output logic                     m_wvalid,
  output logic [pDATA_WIDTH-1:0]   m_wdata,
  output logic [pDATA_WIDTH/8-1:0] m_wstrb,
  input  logic                     m_wready,
  output logic                     m_arvalid,
  output logic [pADDR_WIDTH-1:0]   m_araddr,
  input  logic                     m_arready,
  input  logic                     m_rvalid,
  input  logic [pDATA_WIDTH-1:0]   m_rdata,
  output logic                     m_rready
);
  logic wr_hs, rd_hs, launch;
  // address and data are presented together, so a write finishes only when both are accepted at once
  assign wr_hs = m_awvalid && m_awready && m_wready;
  assign rd_hs = m_rready && m_rvalid;
  assign busy = m_awvalid || m_arvalid || m_rready;
  assign launch = req && !busy;
  assign done = wr_hs || rd_hs;
  assign rdata = m_rdata;
  always_ff @(posedge axi_clk or negedge axi_reset_n)
    if (!axi_reset_n) begin
      m_awvalid <= 1'b0;
      m_wvalid <= 1'b0;
      m_awaddr <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
      m_arvalid <= 1'b0;
      m_araddr <= '0;
      m_rready <= 1'b0;
    end else begin
      if (launch && we) begin
        m_awvalid <= 1'b1;
        m_wvalid <= 1'b1;
        m_awaddr <= addr;
        m_wdata <= wdata;
        m_wstrb <= '1;
      end else if (wr_hs) begin
        m_awvalid <= 1'b0;
        m_wvalid <= 1'b0;
      end
      if (launch && !we) begin
        m_arvalid <= 1'b1;
        m_araddr <= addr;
      end else if (m_arvalid && m_arready) begin
        m_arvalid <= 1'b0;
        m_rready <= 1'b1;
      end else if (rd_hs) m_rready <= 1'b0;
    end
endmodule

// File: rtl/serdes_link_ctrl.sv
// serdes_link_ctrl: serdes link bring-up/shutdown sequencer over AXI-lite.
// Define SERDES_LINK_RETRY_EN to retry a failed bring-up up to three times before ERR.
module serdes_link_ctrl
  import fsic_serdes_pkg::*;
#(
  parameter int pADDR_WIDTH = 15,
  parameter int pDATA_WIDTH = 32,
  parameter int pTMO_WIDTH = 16
) (
  input  logic                     axi_clk,
  input  logic                     axi_reset_n,
  input  logic                     start,
  input  logic                     clr,
  input  logic [pTMO_WIDTH-1:0]    timeout_cfg,
  input  logic                     rx_received,
  output logic                     m_awvalid,
  output logic [pADDR_WIDTH-1:0]   m_awaddr,
  input  logic                     m_awready,
  output logic                     m_wvalid,
  output logic [pDATA_WIDTH-1:0]   m_wdata,
  output logic [pDATA_WIDTH/8-1:0] m_wstrb,
  input  logic                     m_wready,
  output logic                     m_arvalid,
  output logic [pADDR_WIDTH-1:0]   m_araddr,
  input  logic                     m_arready,
  input  logic                     m_rvalid,
  input  logic [pDATA_WIDTH-1:0]   m_rdata,
  output logic                     m_rready,
  output logic                     cc_is_enable,
  output logic                     link_up,
  output logic                     link_err,
  output logic [2:0]               state_o
);
  link_state_t state, nxt, fail_st;
  logic rx_meta, rx_sync, clr_pend, req, we, busy, done, stop, rd_ok;
  logic [pTMO_WIDTH-1:0] tmo_cnt;
  logic [pDATA_WIDTH-1:0] wr_data, rdata, en_mask, rx_mask;
  always_comb begin
    en_mask = '0;
    en_mask[RXEN_BIT] = 1'b1;
    en_mask[TXEN_BIT] = 1'b1;
    rx_mask = '0;
    rx_mask[RXEN_BIT] = 1'b1;
  end
  assign req = (state inside {WR_RX, WR_TX, RD_CHK, WR_OFF}) && !busy;
  assign we = state != RD_CHK;
  assign wr_data = (state == WR_TX) ? en_mask : (state == WR_RX) ? rx_mask : '0;
  assign rd_ok = (rdata & en_mask) == en_mask;
  assign stop = clr || clr_pend;
  assign state_o = state;
`ifdef SERDES_LINK_RETRY_EN
  logic [1:0] retry_cnt;
  assign fail_st = (retry_cnt == 2'd3) ? ERR : WR_RX;
  always_ff @(posedge axi_clk or negedge axi_reset_n)
    if (!axi_reset_n) retry_cnt <= '0;
    else if (clr || (start && state inside {IDLE, ERR}) || nxt == UP) retry_cnt <= '0;
    else if (nxt == WR_RX && state inside {RD_CHK, WAIT_RX}) retry_cnt <= retry_cnt + 2'd1;
`else
  assign fail_st = ERR;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (start && !clr) ? WR_RX : IDLE;
      WR_RX:   nxt = !done ? WR_RX : stop ? WR_OFF : WR_TX;
      WR_TX:   nxt = !done ? WR_TX : stop ? WR_OFF : RD_CHK;
      RD_CHK:  nxt = !done ? RD_CHK : stop ? WR_OFF : rd_ok ? WAIT_RX : fail_st;
      WAIT_RX: nxt = clr ? WR_OFF : rx_sync ? UP : (tmo_cnt == '0) ? fail_st : WAIT_RX;
      UP:      nxt = clr ? WR_OFF : UP;
      ERR:     nxt = clr ? WR_OFF : start ? WR_RX : ERR;
      default: nxt = done ? IDLE : WR_OFF;
    endcase
  end
  // a clr seen mid-transaction is remembered until that transaction's handshake
  always_ff @(posedge axi_clk or negedge axi_reset_n)
    if (!axi_reset_n) begin
      state <= IDLE;
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
      clr_pend <= 1'b0;
      tmo_cnt <= '0;
      link_up <= 1'b0;
      link_err <= 1'b0;
      cc_is_enable <= 1'b0;
    end else begin
      state <= nxt;
      rx_meta <= rx_received;
      rx_sync <= rx_meta;
      clr_pend <= (state inside {WR_RX, WR_TX, RD_CHK}) && !done && stop;
      tmo_cnt <= (nxt == WAIT_RX && state != WAIT_RX) ? timeout_cfg :
                 (state == WAIT_RX && tmo_cnt != '0) ? tmo_cnt - 1'b1 : tmo_cnt;
      link_up <= nxt == UP;
      link_err <= nxt == ERR;
      cc_is_enable <= !(nxt inside {IDLE, ERR});
    end
  serdes_axil_master #(.pADDR_WIDTH(pADDR_WIDTH), .pDATA_WIDTH(pDATA_WIDTH)) u_axil (
    .axi_clk(axi_clk),
    .axi_reset_n(axi_reset_n),
    .req(req),
    .we(we),
    .addr(pADDR_WIDTH'(SERDES_CTRL_OFS)),
    .wdata(wr_data),
    .busy(busy),
    .done(done),
    .rdata(rdata),
    .m_awvalid(m_awvalid),
    .m_awaddr(m_awaddr),
    .m_awready(m_awready),
    .m_wvalid(m_wvalid),
    .m_wdata(m_wdata),
    .m_wstrb(m_wstrb),
    .m_wready(m_wready),
    .m_arvalid(m_arvalid),
    .m_araddr(m_araddr),
    .m_arready(m_arready),
    .m_rvalid(m_rvalid),
    .m_rdata(m_rdata),
    .m_rready(m_rready)
  );
endmodule

// File: tb/tb_serdes_link_ctrl.sv
// tb_serdes_link_ctrl: randomized bring-up/shutdown scenarios against a transaction-level link model
module tb_serdes_link_ctrl;
  localparam logic [2:0] S_IDLE = 3'd0, S_WR_TX = 3'd2, S_RD = 3'd3, S_WAIT = 3'd4, S_UP = 3'd5, S_ERR = 3'd6;
`ifdef SERDES_LINK_RETRY_EN
  localparam int RETRIES = 3;
`else
  localparam int RETRIES = 0;
`endif
  logic axi_clk = 1'b0, axi_reset_n = 1'b0, start = 1'b0, clr = 1'b0, rx_received = 1'b0;
  logic [15:0] timeout_cfg = '0;
  logic m_awvalid, m_wvalid, m_arvalid, m_rready, cc_is_enable, link_up, link_err;
  logic [14:0] m_awaddr, m_araddr;
  logic [31:0] m_wdata;
  logic [3:0] m_wstrb;
  logic [2:0] state_o;
  logic m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  int n_vec = 0, n_bad = 0;
  logic [32:0] obs[$], exp_q[$];
  int wait_obs[$], wait_exp[$];
  int rx_at = -1, dly_max = 0, wd = 0, rd = 0, wcnt = 0;
  logic [31:0] rv = '0;

  serdes_link_ctrl dut (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .start(start), .clr(clr),
    .timeout_cfg(timeout_cfg), .rx_received(rx_received),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready),
    .cc_is_enable(cc_is_enable), .link_up(link_up), .link_err(link_err), .state_o(state_o)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // serdes slave: readies/rvalid after a random delay, logs each transaction as it is accepted
  always @(negedge axi_clk) begin
    if (!axi_reset_n) begin
      m_awready = 0; m_wready = 0; m_arready = 0; m_rvalid = 0; wd = 0; rd = 0;
    end else begin
      if (m_awready) begin
        m_awready = 0; m_wready = 0; wd = $urandom_range(0, dly_max);
      end else if (m_awvalid) begin
        if (wd == 0) begin
          m_awready = 1; m_wready = 1;
          obs.push_back({1'b1, m_wdata});
          check("aw_w_together", m_wvalid, 1);
          check("wr_addr_strb", {m_awaddr, m_wstrb}, {15'd0, 4'hF});
          check("wr_rd_excl", m_arvalid | m_rready, 0);
        end else wd--;
      end
      if (m_arready) begin
        m_arready = 0; rd = $urandom_range(0, dly_max);
      end else if (m_arvalid) begin
        if (rd == 0) begin
          m_arready = 1;
          obs.push_back({1'b0, 32'h0});
          check("rd_addr", m_araddr, 0);
          check("rd_wr_excl", m_awvalid, 0);
        end else rd--;
      end
      if (m_rvalid) m_rvalid = 0;
      else if (m_rready) begin
        if (rd == 0) begin
          m_rvalid = 1; m_rdata = rv; rd = $urandom_range(0, dly_max);
        end else rd--;
      end
    end
  end

  // raise rx_received rx_at cycles into each WAIT_RX visit and record how long each visit lasted
  always @(negedge axi_clk) begin
    if (!axi_reset_n) begin
      wcnt = 0; rx_received = 0;
    end else if (state_o == S_WAIT) begin
      if (wcnt == rx_at) rx_received = 1;
      wcnt++;
    end else if (wcnt != 0) begin
      wait_obs.push_back(wcnt); wcnt = 0; rx_received = 0;
    end
  end

  // link behaviour from the rules: two-flop sync delay, timeout after cfg+1 cycles, retries on failure
  task automatic model(input int cfg, input int m, input logic [31:0] r, output logic [2:0] fin);
    bit rd_good, ok;
    int tries;
    rd_good = r[1:0] == 2'b11;
    ok = rd_good && m >= 0 && m + 2 <= cfg;
    tries = ok ? 1 : RETRIES + 1;
    exp_q.delete(); wait_exp.delete();
    repeat (tries) begin
      exp_q.push_back({1'b1, 32'h1});
      exp_q.push_back({1'b1, 32'h3});
      exp_q.push_back({1'b0, 32'h0});
      if (rd_good) wait_exp.push_back(ok ? m + 3 : cfg + 1);
    end
    exp_q.push_back({1'b1, 32'h0});
    fin = ok ? S_UP : S_ERR;
  endtask

  task automatic wait_st(input logic [2:0] a, input logic [2:0] b);
    for (int i = 0; i < 3000 && state_o != a && state_o != b; i++) @(negedge axi_clk);
  endtask

  task automatic compare_logs();
    check("n_xact", obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) check($sformatf("xact%0d", i), obs[i], exp_q[i]);
    check("n_wait", wait_obs.size(), wait_exp.size());
    for (int i = 0; i < wait_obs.size() && i < wait_exp.size(); i++) check($sformatf("wait%0d", i), wait_obs[i], wait_exp[i]);
  endtask

  task automatic pulse_start();
    @(negedge axi_clk); start = 1;
    @(negedge axi_clk); start = 0;
  endtask

  task automatic scenario(input int cfg, input int m, input logic [31:0] r);
    logic [2:0] fin;
    model(cfg, m, r, fin);
    obs.delete(); wait_obs.delete();
    timeout_cfg = 16'(cfg); rx_at = m; rv = r;
    pulse_start();
    wait_st(S_UP, S_ERR);
    check("outcome", state_o, fin);
    check("flags", {link_up, link_err, cc_is_enable}, (fin == S_UP) ? 3'b101 : 3'b010);
    repeat (3) @(negedge axi_clk);
    check("outcome_hold", state_o, fin);
    clr = 1;
    @(negedge axi_clk); clr = 0;
    wait_st(S_IDLE, S_IDLE);
    check("idle", state_o, S_IDLE);
    check("idle_flags", {link_up, link_err, cc_is_enable}, 3'b000);
    compare_logs();
  endtask

  initial begin
    repeat (3) @(negedge axi_clk);
    check("rst_ctl", {state_o, link_up, link_err, cc_is_enable, m_awvalid, m_wvalid, m_arvalid, m_rready}, 0);
    axi_reset_n = 1;
    dly_max = 0;
    scenario(100, 10, 32'h3);
    scenario(20, -1, 32'h3);
    scenario(20, -1, 32'h1);
    scenario(0, -1, 32'h3);
    // clr while the WR_TX write is waiting for the slave
    dly_max = 2;
    obs.delete(); wait_obs.delete(); wait_exp.delete(); exp_q.delete();
    exp_q.push_back({1'b1, 32'h1}); exp_q.push_back({1'b1, 32'h3}); exp_q.push_back({1'b1, 32'h0});
    rv = 32'h3; timeout_cfg = 16'd50; rx_at = -1;
    pulse_start();
    for (int i = 0; i < 200 && !(state_o == S_WR_TX && m_awvalid); i++) @(negedge axi_clk);
    check("clr_at_wr_tx", {state_o, m_awvalid}, {S_WR_TX, 1'b1});
    clr = 1;
    @(negedge axi_clk); clr = 0;
    wait_st(S_IDLE, S_IDLE);
    check("clr_idle", {state_o, link_up, link_err, cc_is_enable}, {S_IDLE, 3'b000});
    compare_logs();
    // reset with a read address pending
    dly_max = 0;
    obs.delete();
    rv = 32'h3; timeout_cfg = 16'd50; rx_at = 5;
    pulse_start();
    for (int i = 0; i < 200 && !(state_o == S_RD && m_arvalid); i++) @(negedge axi_clk);
    check("rd_pending", {state_o, m_arvalid}, {S_RD, 1'b1});
    axi_reset_n = 0;
    @(posedge axi_clk); #1;
    check("rst_mid_ctl", {state_o, link_up, link_err, cc_is_enable, m_awvalid, m_wvalid, m_arvalid, m_rready}, 0);
    check("rst_mid_addr", {m_awaddr, m_araddr, m_wstrb}, 0);
    check("rst_mid_wdata", m_wdata, 0);
    @(negedge axi_clk); axi_reset_n = 1;
    scenario(50, 5, 32'h3);
    // start and clr together in IDLE
    obs.delete();
    @(negedge axi_clk); start = 1; clr = 1;
    @(negedge axi_clk); start = 0; clr = 0;
    repeat (6) @(negedge axi_clk);
    check("sc_state", state_o, S_IDLE);
    check("sc_traffic", obs.size(), 0);
    check("sc_cc", cc_is_enable, 0);
    for (int k = 0; k < 24; k++) begin
      int kind, cfg, m;
      logic [31:0] r;
      kind = $urandom_range(0, 3);
      cfg = $urandom_range(2, 40);
      dly_max = $urandom_range(0, 3);
      r = $urandom;
      r[1:0] = 2'b11;
      case (kind)
        0: m = $urandom_range(0, cfg - 2);
        1: m = cfg - 2 + $urandom_range(0, 1);
        2: begin m = -1; cfg = $urandom_range(0, 25); end
        default: begin m = 0; r[1:0] = 2'($urandom_range(0, 2)); end
      endcase
      scenario(cfg, m, r);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end
endmodule
